led_matrix_scanner: RTL

Self-timed, parametrised successor to the combinational LED array driver. It owns the row-scan counter, per-row dwell timing and PWM brightness, so callers no longer supply a row index. It holds a double-buffered frame: a new frame is loaded via a valid/ready handshake and becomes visible only at a frame boundary, which prevents tearing. It sits between the game-of-life core and the physical ROWSxCOLS LED matrix.

---
 rtl/led_matrix_pkg.sv | 31 +++
 rtl/led_frame_buffer.sv | 55 +++++
 rtl/led_matrix_scanner.sv | 136 +++++++++++++
 3 files changed

// File: rtl/led_matrix_pkg.sv
// Shared constants and helpers for the LED matrix scanner.
// Cell (r, c) of a frame lives at bit r*COLS + c.
package led_matrix_pkg;

    localparam int DEFAULT_ROWS     = 8;
    localparam int DEFAULT_COLS     = 8;
    localparam int DEFAULT_DWELL    = 1024;
    localparam int DEFAULT_PWM_BITS = 4;

    localparam int ONEHOT_MAX = 64;

    function automatic logic [ONEHOT_MAX-1:0] onehot(
        input logic [31:0] idx
    );
        logic [ONEHOT_MAX-1:0] v;
        v = '0;
        if (idx < ONEHOT_MAX) begin
            v[idx[5:0]] = 1'b1;
        end
        return v;
    endfunction

    function automatic int unsigned cell_idx(
        input int unsigned r,
        input int unsigned c,
        input int unsigned ncols
    );
        return r * ncols + c;
    endfunction

endpackage

// File: rtl/led_frame_buffer.sv
// Double-buffered frame store: a loaded frame waits in pending
// until the scanner requests a swap at a frame boundary.
module led_frame_buffer
    import led_matrix_pkg::*;
#(
    parameter int CELLS = DEFAULT_ROWS * DEFAULT_COLS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CELLS-1:0] cells_in,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             swap_req,
    output logic [CELLS-1:0] active
);

    logic [CELLS-1:0] pending_q;
    logic [CELLS-1:0] pending_d;
    logic [CELLS-1:0] active_q;
    logic [CELLS-1:0] active_d;
    logic             pending_full_q;
    logic             pending_full_d;
    logic             take;

    assign load_ready = !pending_full_q;
    assign active     = active_q;

    // Ready is low while pending is full, so a load and a swap never collide.
    always_comb begin
        pending_d      = pending_q;
        active_d       = active_q;
        pending_full_d = pending_full_q;
        take           = load_valid && !pending_full_q;
        if (pending_full_q && swap_req) begin
            active_d       = pending_q;
            pending_full_d = 1'b0;
        end else if (take) begin
            pending_d      = cells_in;
            pending_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q      <= '0;
            active_q       <= '0;
            pending_full_q <= 1'b0;
        end else begin
            pending_q      <= pending_d;
            active_q       <= active_d;
            pending_full_q <= pending_full_d;
        end
    end

endmodule

// File: rtl/led_matrix_scanner.sv
// Self-timed row scanner with per-row dwell, PWM brightness and a
// tear-free double-buffered frame.
module led_matrix_scanner
    import led_matrix_pkg::*;
#(
    parameter int ROWS         = DEFAULT_ROWS,
    parameter int COLS         = DEFAULT_COLS,
    parameter int DWELL_CYCLES = DEFAULT_DWELL,
    parameter int PWM_BITS     = DEFAULT_PWM_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic [ROWS*COLS-1:0] cells_in,
    input  logic                 load_valid,
    output logic                 load_ready,
    input  logic [PWM_BITS-1:0]  brightness,
    output logic [ROWS-1:0]      rows,
    output logic [COLS-1:0]      cols,
    output logic                 frame_start
);

    localparam int RW = $clog2(ROWS);
    localparam int DW = $clog2(DWELL_CYCLES);
    localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);

    logic [RW-1:0]         row_cnt_q;
    logic [RW-1:0]         row_cnt_d;
    logic [DW-1:0]         dwell_cnt_q;
    logic [DW-1:0]         dwell_cnt_d;
    logic [PWM_BITS-1:0]   pwm_cnt_q;
    logic [PWM_BITS-1:0]   pwm_cnt_d;
    logic [PWM_BITS-1:0]   bright_q;
    logic [PWM_BITS-1:0]   bright_d;
    logic [ROWS-1:0]       rows_q;
    logic [ROWS-1:0]       rows_d;
    logic [COLS-1:0]       cols_q;
    logic [COLS-1:0]       cols_d;
    logic                  frame_start_q;
    logic                  frame_start_d;

    logic                  row_last;
    logic                  dwell_last;
    logic                  row_first;
    logic                  swap_req;
    logic [PWM_BITS-1:0]   bright_eff;
    logic [COLS-1:0]       row_bits;
    logic [ONEHOT_MAX-1:0] row_oh;
    logic [ROWS*COLS-1:0]  active;

    led_frame_buffer #(
        .CELLS(ROWS * COLS)
    ) u_fb (
        .clk       (clk),
        .rst       (rst),
        .cells_in  (cells_in),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .swap_req  (swap_req),
        .active    (active)
    );

    always_comb begin
        row_last   = (row_cnt_q == ROW_LAST);
        dwell_last = (dwell_cnt_q == DWELL_LAST);
        row_first  = (dwell_cnt_q == '0);
        swap_req   = !ena || (row_last && dwell_last);
    end

    always_comb begin
        row_cnt_d   = row_cnt_q;
        dwell_cnt_d = dwell_cnt_q;
        pwm_cnt_d   = pwm_cnt_q;
        bright_d    = bright_q;
        if (!ena) begin
            row_cnt_d   = '0;
            dwell_cnt_d = '0;
            pwm_cnt_d   = '0;
            bright_d    = '0;
        end else begin
            if (row_first) begin
                bright_d = brightness;
            end
            if (dwell_last) begin
                dwell_cnt_d = '0;
                pwm_cnt_d   = '0;
                row_cnt_d   = row_last ? '0 : row_cnt_q + RW'(1);
            end else begin
                dwell_cnt_d = dwell_cnt_q + DW'(1);
                pwm_cnt_d   = pwm_cnt_q + PWM_BITS'(1);
            end
        end
    end

    // The row's first cycle compares against the live input so a new
    // brightness is visible from the very start of the row.
    always_comb begin
        bright_eff = row_first ? brightness : bright_q;
        row_bits   = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (row_cnt_q == RW'(r)) begin
                row_bits = active[r*COLS +: COLS];
            end
        end
        row_oh        = onehot(32'(row_cnt_q));
        rows_d        = ena ? row_oh[ROWS-1:0] : '0;
        cols_d        = (ena && (pwm_cnt_q < bright_eff)) ? row_bits : '0;
        frame_start_d = ena && (row_cnt_q == '0) && row_first;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_cnt_q     <= '0;
            dwell_cnt_q   <= '0;
            pwm_cnt_q     <= '0;
            bright_q      <= '0;
            rows_q        <= '0;
            cols_q        <= '0;
            frame_start_q <= 1'b0;
        end else begin
            row_cnt_q     <= row_cnt_d;
            dwell_cnt_q   <= dwell_cnt_d;
            pwm_cnt_q     <= pwm_cnt_d;
            bright_q      <= bright_d;
            rows_q        <= rows_d;
            cols_q        <= cols_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign rows        = rows_q;
    assign cols        = cols_q;
    assign frame_start = frame_start_q;

endmodule
